uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the processor's data-memory bus, alongside `dmem`. It consumes the processor's store traffic (`MemWrite`, `ALUResult`, `WriteData`) and queues bytes written to its TX register in a small FIFO. It serializes those bytes as 8N1 frames on `tx`, and exposes a status register that `ldr` can read back. The top level muxes `rd_data` over `dmem`'s read data whenever `sel` is high.

---
 rtl/uart_mmio_pkg.sv | 19 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/uart_tx_mmio.sv | 152 +++++++++++++++
 tb/tb_uart_tx_mmio.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_mmio_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_FULL  = 2;
  localparam int unsigned STAT_OVF   = 3;

  localparam logic [31:0] DEF_TX_ADDR   = 32'h0000_0100;
  localparam logic [31:0] DEF_STAT_ADDR = 32'h0000_0104;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output; a pop frees its slot for a
// push arriving in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rptr_q];

  always_comb begin
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: only entries covered by count_q are ever read out.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to the TX register queue bytes,
// the status register reports {overflow, full, empty, busy}.
module uart_tx_mmio
  import uart_mmio_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_ADDR      = DEF_TX_ADDR,
  parameter logic [31:0] STAT_ADDR    = DEF_STAT_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);

  tx_state_e        state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             ovf_q, ovf_d;

  logic       hit_tx, hit_stat, push_req, clr_ovf, drop, pop, baud_end;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_head;
  logic [3:0] status;
  logic       unused_wr_data;

  assign unused_wr_data = ^wr_data[31:8];

  assign hit_tx   = (addr == TX_ADDR);
  assign hit_stat = (addr == STAT_ADDR);
  assign sel      = hit_tx || hit_stat;
  assign push_req = mem_write && hit_tx;
  assign clr_ovf  = mem_write && hit_stat && wr_data[3];
  assign drop     = push_req && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .din   (wr_data[7:0]),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow; a drop in the clearing cycle wins.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end

  assign baud_end = (baud_q == BaudMax);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          baud_d  = '0;
          bit_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      StStart: tx = 1'b0;
      StData:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (state_q != StIdle) || !fifo_empty;

  always_comb begin
    status             = '0;
    status[STAT_BUSY]  = busy;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_FULL]  = fifo_full;
    status[STAT_OVF]   = ovf_q;
  end

  assign rd_data = hit_stat ? {28'b0, status} : 32'b0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLKS_PER_BIT = 4 and an 8-deep FIFO.
module tb_uart_tx_mmio;

  localparam int unsigned CPB = 4;
  localparam logic [31:0] TXA = 32'h0000_0100;
  localparam logic [31:0] STA = 32'h0000_0104;

  logic        clk, rst, mem_write, sel, tx, busy;
  logic [31:0] addr, wr_data, rd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cycles = 0;
  int n_falls = 0;

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8),
    .TX_ADDR      (TXA),
    .STAT_ADDR    (STA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_write (mem_write),
    .addr      (addr),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .sel       (sel),
    .tx        (tx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (busy) busy_cycles++;
  always @(negedge tx) n_falls++;

  typedef struct {
    logic [31:0] addr;
    logic        mw;
    logic [31:0] wd;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vec [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive one store for exactly one rising edge; returns at the following negedge.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wr_data = d;
    mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  // Called at the negedge that shows the first start-bit cycle.
  task automatic expect_frame(input string name, input logic [7:0] b);
    logic [9:0] f;
    logic [3:0] seen;
    f = {1'b1, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < CPB; c++) begin
        seen[c] = tx;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d", name, j), 32'(seen), 32'({4{f[j]}}));
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec[0] = '{addr: TXA,            mw: 1'b0, wd: 32'h55, exp_sel: 1'b1, exp_rd: 32'h0};
    vec[1] = '{addr: STA,            mw: 1'b0, wd: 32'h00, exp_sel: 1'b1, exp_rd: 32'h2};
    vec[2] = '{addr: 32'h0000_0108,  mw: 1'b1, wd: 32'h55, exp_sel: 1'b0, exp_rd: 32'h0};
    vec[3] = '{addr: 32'h0000_0000,  mw: 1'b1, wd: 32'hAA, exp_sel: 1'b0, exp_rd: 32'h0};
    vec[4] = '{addr: STA,            mw: 1'b1, wd: 32'h08, exp_sel: 1'b1, exp_rd: 32'h2};
    vec[5] = '{addr: 32'h0000_0101,  mw: 1'b1, wd: 32'h11, exp_sel: 1'b0, exp_rd: 32'h0};
    vec[6] = '{addr: 32'h1000_0100,  mw: 1'b1, wd: 32'h22, exp_sel: 1'b0, exp_rd: 32'h0};

    mem_write = 1'b0;
    addr = STA;
    wr_data = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_status", rd_data, 32'h2);
    rst = 1'b1;
    @(negedge clk);

    // Address decode and non-push stores
    for (int i = 0; i < 7; i++) begin
      addr = vec[i].addr;
      wr_data = vec[i].wd;
      mem_write = vec[i].mw;
      #1;
      check($sformatf("dec%0d_sel", i), 32'(sel), 32'(vec[i].exp_sel));
      check($sformatf("dec%0d_rd", i), rd_data, vec[i].exp_rd);
      @(negedge clk);
      mem_write = 1'b0;
      check($sformatf("dec%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("dec%0d_tx", i), 32'(tx), 32'd1);
    end

    // Single frame of 0x55
    busy_cycles = 0;
    store(TXA, 32'h55);
    check("single_tx_before_pop", 32'(tx), 32'd1);
    check("single_busy_rise", 32'(busy), 32'd1);
    addr = STA;
    #1 check("status_pending", rd_data, 32'h1);
    @(negedge clk);
    check("status_in_frame", rd_data, 32'h3);
    addr = TXA;
    #1 check("rd_zero_off_stat", rd_data, 32'h0);
    expect_frame("f55", 8'h55);
    check("single_tx_end", 32'(tx), 32'd1);
    check("single_busy_fall", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);
    check("single_busy_cycles", 32'(busy_cycles), 32'd41);

    // Back-to-back frames
    store(TXA, 32'hA3);
    store(TXA, 32'h01);
    expect_frame("fA3", 8'hA3);
    check("gap_idle_tx", 32'(tx), 32'd1);
    @(negedge clk);
    expect_frame("f01", 8'h01);
    check("b2b_tx_end", 32'(tx), 32'd1);
    check("b2b_busy_end", 32'(busy), 32'd0);

    // Overflow: 10 consecutive stores, 9 accepted
    n_falls = 0;
    for (int i = 0; i < 10; i++) store(TXA, 32'hFF);
    addr = STA;
    #1 check("ovf_status", rd_data, 32'hD);
    store(STA, 32'h07);
    #1 check("ovf_no_clear", rd_data, 32'hD);
    store(STA, 32'h08);
    #1 check("ovf_cleared", rd_data, 32'h5);
    wait_idle("ovf", 600);
    check("ovf_frames", 32'(n_falls), 32'd9);
    check("ovf_final_status", rd_data, 32'h2);

    // Reset in the middle of a frame with 3 bytes queued
    for (int i = 0; i < 4; i++) store(TXA, 32'h00);
    repeat (10) @(negedge clk);
    addr = STA;
    #1;
    check("rst_pre_tx", 32'(tx), 32'd0);
    check("rst_pre_status", rd_data, 32'h1);
    #1 rst = 1'b0;
    #1;
    check("rst_async_tx", 32'(tx), 32'd1);
    check("rst_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    n_falls = 0;
    repeat (60) @(negedge clk);
    check("rst_no_frames", 32'(n_falls), 32'd0);
    check("rst_status", rd_data, 32'h2);
    check("rst_tx_idle", 32'(tx), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
